// File: rtl/capture_buffer_reader_pkg.sv
// Shared state encodings and helpers for the ADC capture double buffer.
// Imported by the reader and by the ADC driver.
package capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_HEADER = 2'd2,
    ST_STREAM = 2'd3
  } state_t;

  // Distance from the trigger back to the oldest sample of the record.
  function automatic int half_offset(input int depth);
    return 1 << (depth - 1);
  endfunction

endpackage

// File: rtl/capture_buffer_reader_if.sv
// Bus bundle for capture_buffer_reader: bank handshake, memory read
// port and output stream. master = reader side, slave = environment.
interface capture_buffer_reader_if #(
  parameter int DEPTH = 11,
  parameter int DW    = 12
);
  logic           cap_valid;
  logic           cap_ready;
  logic [DEPTH:0] trig_addr;
  logic           cs_n;
  logic           rd_en;
  logic [DEPTH:0] rd_addr;
  logic [DW-1:0]  rd_data;
  logic [DW-1:0]  m_data;
  logic           m_valid;
  logic           m_ready;
  logic           m_last;
  logic           busy;

  modport master (
    input  cap_valid, trig_addr, cs_n, rd_data, m_ready,
    output cap_ready, rd_en, rd_addr, m_data, m_valid, m_last, busy
  );

  modport slave (
    output cap_valid, trig_addr, cs_n, rd_data, m_ready,
    input  cap_ready, rd_en, rd_addr, m_data, m_valid, m_last, busy
  );
endinterface

// File: rtl/capture_buffer_reader_fifo.sv
// reader_skid_fifo: 2-entry {last, data} FIFO, the stream output register.
// Ports: i_push/i_din write, i_pop read, o_dout head, o_valid, o_count.
module reader_skid_fifo #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic         o_valid,
  output logic [1:0]   o_count
);
  logic [W-1:0] r_mem [2];
  logic         r_wp;
  logic         r_rp;
  logic [1:0]   r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wp] <= i_din;
        r_wp        <= ~r_wp;
      end
      if (i_pop)
        r_rp <= ~r_rp;
      r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  assign o_dout  = r_mem[r_rp];
  assign o_valid = (r_count != 2'd0);
  assign o_count = r_count;
endmodule

// File: rtl/capture_buffer_reader.sv
// Takes a filled capture bank and streams it oldest-first as a circular
// record of 2**DEPTH samples centred on the trigger.
// Ports: clk, rst (async, active high), bus (capture_buffer_reader_if.master).
// Macro READER_HEADER_EN: prepend one word holding trig_addr to each record.
module capture_buffer_reader
  import capture_pkg::*;
#(
  parameter int DEPTH = 11,
  parameter int DW    = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  capture_buffer_reader_if.master bus
);
  localparam logic [DEPTH:0] N_REC = {1'b1, {DEPTH{1'b0}}};

  state_t           r_state;
  state_t           w_next;
  logic             r_bank;
  logic [DEPTH-1:0] r_offs;
  logic [DEPTH:0]   r_rem;
  logic             r_infl;
  logic             r_infl_last;

  logic             w_cap_ready;
  logic             w_xfer;
  logic             w_rd_en;
  logic             w_busy;
  logic             w_room;
  logic             w_push;
  logic [DW:0]      w_din;
  logic             w_pop;
  logic [DW:0]      w_fdout;
  logic             w_fvalid;
  logic [1:0]       w_fcount;

  assign w_pop  = w_fvalid & bus.m_ready;
  assign w_xfer = bus.cap_valid & w_cap_ready;

  // Credit includes a same-cycle pop so reads keep up at 1 word/cycle
  // while the FIFO plus the read in flight never exceeds 2 entries.
  assign w_room = (int'(w_fcount) + int'(r_infl) - int'(w_pop)) < 2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:
        if (w_xfer) w_next = ST_LOAD;
`ifdef READER_HEADER_EN
      ST_LOAD:   w_next = ST_HEADER;
      ST_HEADER:
        if (w_pop) w_next = ST_STREAM;
`else
      ST_LOAD:   w_next = ST_STREAM;
`endif
      ST_STREAM:
        if (w_pop && w_fdout[DW]) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_cap_ready = (r_state == ST_IDLE) & bus.cs_n & ~rst;
    w_rd_en     = (r_state == ST_STREAM) && (r_rem != '0) && w_room;
    w_busy      = (r_state != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bank      <= 1'b0;
      r_offs      <= '0;
      r_rem       <= '0;
      r_infl      <= 1'b0;
      r_infl_last <= 1'b0;
    end else begin
      if (r_state == ST_LOAD) begin
        r_bank <= bus.trig_addr[DEPTH];
        r_offs <= bus.trig_addr[DEPTH-1:0] - DEPTH'(half_offset(DEPTH));
        r_rem  <= N_REC;
      end else if (w_rd_en) begin
        r_offs <= r_offs + DEPTH'(1);
        r_rem  <= r_rem - (DEPTH+1)'(1);
      end
      r_infl      <= w_rd_en;
      r_infl_last <= w_rd_en && (r_rem == (DEPTH+1)'(1));
    end
  end

`ifdef READER_HEADER_EN
  // trig_addr is valid during LOAD, so the header goes straight in.
  assign w_push = r_infl | (r_state == ST_LOAD);
  assign w_din  = (r_state == ST_LOAD)
                ? {1'b0, DW'(bus.trig_addr)}
                : {r_infl_last, bus.rd_data};
`else
  assign w_push = r_infl;
  assign w_din  = {r_infl_last, bus.rd_data};
`endif

  reader_skid_fifo #(.W(DW + 1)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_dout  (w_fdout),
    .o_valid (w_fvalid),
    .o_count (w_fcount)
  );

  assign bus.cap_ready = w_cap_ready;
  assign bus.rd_en     = w_rd_en;
  assign bus.rd_addr   = {r_bank, r_offs};
  assign bus.busy      = w_busy;
  assign bus.m_valid   = w_fvalid;
  assign bus.m_data    = w_fdout[DW-1:0];
  assign bus.m_last    = w_fdout[DW] & w_fvalid;
endmodule

// File: tb/tb_capture_buffer_reader.sv
// Directed bench for capture_buffer_reader at DEPTH=4, DW=12.
// Memory holds address-as-data; records checked against a local model.
module tb_capture_buffer_reader;
`ifdef READER_HEADER_EN
  localparam int H = 1;
`else
  localparam int H = 0;
`endif
  localparam int NW = 16 + H;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [4:0]  got_addr [$];
  logic [11:0] got_data [$];
  logic        got_last [$];
  int          first_c;
  int          last_c;
  int          tmo;
  logic [11:0] mem [32];

  capture_buffer_reader_if #(.DEPTH(4), .DW(12)) bus ();

  capture_buffer_reader #(.DEPTH(4), .DW(12)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];

  function automatic logic [4:0] exp_addr(input logic [4:0] t, input int j);
    logic [3:0] off;
    off = t[3:0] - 4'd8 + 4'(j);
    return {t[4], off};
  endfunction

  function automatic logic [12:0] exp_word(input logic [4:0] t, input int i);
    int j;
    if (H == 1 && i == 0) return {1'b0, 7'd0, t};
    j = i - H;
    return {(j == 15), 7'd0, exp_addr(t, j)};
  endfunction

  task automatic run_record(input logic [4:0] t, input int mode,
                            input int stop_at);
    int   c;
    int   n;
    logic done;
    logic stall;
    logic [11:0] sd;
    logic sl;
    got_addr.delete();
    got_data.delete();
    got_last.delete();
    first_c = -1;
    last_c  = -1;
    tmo     = 0;
    stall   = 1'b0;
    sd      = '0;
    sl      = 1'b0;
    bus.trig_addr = t;
    bus.cs_n      = 1'b1;
    bus.cap_valid = 1'b1;
    n = 0;
    #1;
    while (!bus.cap_ready && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.cap_ready) tmo = 1;
    @(negedge clk);
    bus.cap_valid = 1'b0;
    c    = 1;
    done = (tmo != 0);
    while (!done && c < 300) begin
      bus.m_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (stop_at > 0 && got_data.size() == stop_at - 1 && bus.m_valid) begin
        rst = 1'b1;
        return;
      end
      if (bus.rd_en) got_addr.push_back(bus.rd_addr);
      if (stall) begin
        checks++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== sd || bus.m_last !== sl) begin
          errors++;
          $display("FAIL hold: valid=%b data=%h last=%b want data=%h last=%b",
                   bus.m_valid, bus.m_data, bus.m_last, sd, sl);
        end
      end
      if (mode == 1) begin
        checks++;
        if (u_dut.u_fifo.r_count > 2'd2) begin
          errors++;
          $display("FAIL fifo_count: got %0d want <=2", u_dut.u_fifo.r_count);
        end
      end
      stall = bus.m_valid && !bus.m_ready;
      sd    = bus.m_data;
      sl    = bus.m_last;
      if (bus.m_valid && bus.m_ready) begin
        if (first_c < 0) first_c = c;
        last_c = c;
        got_data.push_back(bus.m_data);
        got_last.push_back(bus.m_last);
        if (bus.m_last) done = 1'b1;
      end
      @(negedge clk);
      c++;
    end
    if (!done) tmo = 1;
  endtask

  task automatic test_reset();
    bus.cs_n      = 1'b1;
    bus.cap_valid = 1'b1;
    bus.m_ready   = 1'b1;
    bus.trig_addr = '0;
    #3;
    checks++;
    if ({bus.cap_ready, bus.rd_en, bus.m_valid, bus.m_last, bus.busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctl: got %b want 00000",
               {bus.cap_ready, bus.rd_en, bus.m_valid, bus.m_last, bus.busy});
    end
    checks++;
    if (bus.rd_addr !== 5'd0 || bus.m_data !== 12'd0) begin
      errors++;
      $display("FAIL reset_data: rd_addr=%h m_data=%h want 0", bus.rd_addr, bus.m_data);
    end
    bus.cap_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.cap_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: cap_ready=%b busy=%b want 1 0",
               bus.cap_ready, bus.busy);
    end
  endtask

  task automatic test_wrap();
    logic [4:0] t;
    t = 5'b1_0011;
    @(negedge clk);
    run_record(t, 0, 0);
    checks++;
    if (tmo != 0 || got_addr.size() != 16 || got_data.size() != NW) begin
      errors++;
      $display("FAIL wrap_len: tmo=%0d addrs=%0d words=%0d want 0 16 %0d",
               tmo, got_addr.size(), got_data.size(), NW);
    end
    for (int i = 0; i < 16 && i < got_addr.size(); i++) begin
      checks++;
      if (got_addr[i] !== exp_addr(t, i)) begin
        errors++;
        $display("FAIL wrap_addr[%0d]: got %h want %h", i, got_addr[i], exp_addr(t, i));
      end
    end
    for (int i = 0; i < NW && i < got_data.size(); i++) begin
      checks++;
      if ({got_last[i], got_data[i]} !== exp_word(t, i)) begin
        errors++;
        $display("FAIL wrap_word[%0d]: got %b_%h want %h",
                 i, got_last[i], got_data[i], exp_word(t, i));
      end
    end
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.cap_ready !== 1'b1) begin
      errors++;
      $display("FAIL wrap_end: busy=%b cap_ready=%b want 0 1", bus.busy, bus.cap_ready);
    end
  endtask

  task automatic test_nowrap();
    logic [4:0] t;
    t = 5'b0_1000;
    @(negedge clk);
    run_record(t, 0, 0);
    checks++;
    if (tmo != 0 || got_data.size() != NW) begin
      errors++;
      $display("FAIL nowrap_len: tmo=%0d words=%0d want 0 %0d", tmo, got_data.size(), NW);
    end
    for (int i = 0; i < 16 && i < got_addr.size(); i++) begin
      checks++;
      if (got_addr[i] !== 5'(i)) begin
        errors++;
        $display("FAIL nowrap_addr[%0d]: got %h want %h", i, got_addr[i], 5'(i));
      end
    end
    for (int i = 0; i < NW && i < got_data.size(); i++) begin
      checks++;
      if ({got_last[i], got_data[i]} !== exp_word(t, i)) begin
        errors++;
        $display("FAIL nowrap_word[%0d]: got %b_%h want %h",
                 i, got_last[i], got_data[i], exp_word(t, i));
      end
    end
    checks++;
    if (first_c != (H == 1 ? 2 : 4) || last_c != (H == 1 ? 20 : 19)) begin
      errors++;
      $display("FAIL nowrap_timing: first=%0d last=%0d want %0d %0d",
               first_c, last_c, (H == 1 ? 2 : 4), (H == 1 ? 20 : 19));
    end
  endtask

  task automatic test_random();
    logic [4:0] t;
    t = 5'b1_0110;
    @(negedge clk);
    run_record(t, 1, 0);
    checks++;
    if (tmo != 0 || got_data.size() != NW) begin
      errors++;
      $display("FAIL rand_len: tmo=%0d words=%0d want 0 %0d", tmo, got_data.size(), NW);
    end
    for (int i = 0; i < NW && i < got_data.size(); i++) begin
      checks++;
      if ({got_last[i], got_data[i]} !== exp_word(t, i)) begin
        errors++;
        $display("FAIL rand_word[%0d]: got %b_%h want %h",
                 i, got_last[i], got_data[i], exp_word(t, i));
      end
    end
  endtask

  task automatic test_cs();
    int   n;
    int   words;
    logic done;
    logic seen_rdy;
    @(negedge clk);
    bus.trig_addr = 5'b0_0111;
    bus.cs_n      = 1'b0;
    bus.cap_valid = 1'b1;
    bus.m_ready   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus.cap_ready !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL cs_hold[%0d]: cap_ready=%b busy=%b want 0 0",
                 i, bus.cap_ready, bus.busy);
      end
      @(negedge clk);
    end
    bus.cs_n = 1'b1;
    #1;
    checks++;
    if (bus.cap_ready !== 1'b1) begin
      errors++;
      $display("FAIL cs_release: cap_ready=%b want 1", bus.cap_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL cs_xfer: busy=%b want 1", bus.busy);
    end
    n = 0;
    words = 0;
    done = 1'b0;
    seen_rdy = 1'b0;
    while (!done && n < 200) begin
      bus.cs_n = n[0];
      if (words == 8) bus.cap_valid = 1'b0;
      #1;
      if (bus.cap_ready) seen_rdy = 1'b1;
      if (bus.m_valid) begin
        words++;
        if (bus.m_last) done = 1'b1;
      end
      @(negedge clk);
      n++;
    end
    bus.cap_valid = 1'b0;
    bus.cs_n = 1'b1;
    checks++;
    if (seen_rdy !== 1'b0 || words != NW || !done) begin
      errors++;
      $display("FAIL cs_record: rdy_seen=%b words=%0d done=%b want 0 %0d 1",
               seen_rdy, words, done, NW);
    end
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.cap_ready !== 1'b1) begin
      errors++;
      $display("FAIL cs_no_second: busy=%b cap_ready=%b want 0 1",
               bus.busy, bus.cap_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] t;
    @(negedge clk);
    run_record(5'b1_0011, 0, 7 + H);
    #1;
    checks++;
    if ({bus.cap_ready, bus.rd_en, bus.m_valid, bus.m_last, bus.busy} !== 5'b0 ||
        bus.rd_addr !== 5'd0 || bus.m_data !== 12'd0) begin
      errors++;
      $display("FAIL mid_reset: ctl=%b rd_addr=%h m_data=%h want 0",
               {bus.cap_ready, bus.rd_en, bus.m_valid, bus.m_last, bus.busy},
               bus.rd_addr, bus.m_data);
    end
    @(negedge clk);
    rst = 1'b0;
    t = 5'b0_0101;
    run_record(t, 0, 0);
    checks++;
    if (tmo != 0 || got_addr.size() != 16 || got_data.size() != NW) begin
      errors++;
      $display("FAIL restart_len: tmo=%0d addrs=%0d words=%0d",
               tmo, got_addr.size(), got_data.size());
    end
    for (int i = 0; i < 16 && i < got_addr.size(); i++) begin
      checks++;
      if (got_addr[i] !== exp_addr(t, i)) begin
        errors++;
        $display("FAIL restart_addr[%0d]: got %h want %h", i, got_addr[i], exp_addr(t, i));
      end
    end
    for (int i = 0; i < NW && i < got_data.size(); i++) begin
      checks++;
      if ({got_last[i], got_data[i]} !== exp_word(t, i)) begin
        errors++;
        $display("FAIL restart_word[%0d]: got %b_%h want %h",
                 i, got_last[i], got_data[i], exp_word(t, i));
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 32; a++) mem[a] = 12'(a);
    bus.rd_data = '0;
    test_reset();
    test_wrap();
    test_nowrap();
    test_random();
    test_cs();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
